ex_mem_wb_stage: RTL and testbench
==================================

// Module: ex_mem_wb_stage
// PURPOSE
// - Pipeline stage directly downstream of the ID/EX register and the EX-stage ALU.
// - Holds the EX/MEM register and sequences the data-memory request/dhit handshake.
// - Freezes upstream stages (mem_stall) while a load or store is pending.
// - Selects write-back data and drives the registered MEM/WB outputs to the register file.
// - Makes halt sticky.
// PARAMETERS
// - DATA_W  32  datapath width (aluout, store data, load data, NPC, upper value)
// - CNT_W   16  width of the saturating memory-stall cycle counter
// PORTS
// - CLK             in   1       clock, rising edge
// - nRST            in   1       async reset, active-low
// - ex_aluout       in   DATA_W  ALU result; dmem address for loads/stores
// - ex_storedata    in   DATA_W  forwarded rt value for SW
// - ex_npc          in   DATA_W  PC+4 (JAL link value)
// - ex_upper        in   DATA_W  LUI value {imm,16'h0}
// - ex_wsel         in   5       destination register
// - ex_regwrite     in   1       write-back enable
// - ex_memtoreg     in   2       wdat select: 0 alu, 1 load, 2 npc, 3 upper
// - ex_dmemREN      in   1       load request
// - ex_dmemWEN      in   1       store request
// - ex_halt         in   1       HALT in EX
// - flush           in   1       squash EX instruction (branch/jump resolved)
// - dhit            in   1       dmem access complete this cycle
// - dmemload        in   DATA_W  load data, valid when dhit
// - dmemREN         out  1       load request to cache
// - dmemWEN         out  1       store request to cache
// - dmemaddr        out  DATA_W  = latched aluout
// - dmemstore       out  DATA_W  = latched storedata
// - mem_stall       out  1       freeze IF/ID, ID/EX and this stage's EX/MEM register
// - wb_regwrite     out  1       registered regfile WEN
// - wb_wsel         out  5       registered regfile wsel
// - wb_wdat         out  DATA_W  registered regfile wdat
// - halt            out  1       sticky halt to system
// - stall_cycles    out  CNT_W   saturating count of mem_stall cycles
// BEHAVIOUR
// - Reset (async, nRST low): all EX/MEM, MEM/WB, FSM, halt and counter state = 0; state = RUN. All outputs 0.
//
// - EX/MEM register (mem_* fields): updated on each CLK edge unless mem_stall=1 or state=HALTED.
//   - Loaded from ex_*.
//   - If flush=1 the edge loads a bubble: regwrite, dmemREN, dmemWEN and halt = 0; data fields are don't-care.
//   - mem_stall=1 has priority over flush: the register holds and flush is ignored.
//
// - FSM states:
//   - RUN
//     - mem_req = (mem_dmemREN | mem_dmemWEN).
//     - dmemREN/WEN = the latched bits.
//     - mem_stall = mem_req & ~dhit (combinational).
//     - Latched halt=1 with no mem_req -> HALTED at the next edge.
//     - REN and WEN both set: treated as a store (dmemWEN=1, dmemREN=0).
//   - HALTED (terminal until reset)
//     - dmemREN = dmemWEN = 0; mem_stall = 1.
//     - wb_regwrite = 0 from the following edge.
//     - halt = 1 from the edge that enters HALTED.
//
// - Handshake: requests are level signals held stable (addr/store/REN/WEN) until the cycle dhit=1.
//   - On that same edge the stage advances and the request drops.
//   - dhit with no request pending is ignored.
//   - No combinational path from dhit to dmemREN/WEN.
//
// - MEM/WB register: updated every edge in RUN when mem_stall=0; loaded with
//   - wb_regwrite = mem_regwrite & (wsel != 0)
//   - wb_wsel = mem_wsel
//   - wb_wdat = per mem_memtoreg (1 selects dmemload)
//   - When mem_stall=1 the MEM/WB register loads a bubble (wb_regwrite=0) so a write never repeats.
//
// - Latency: non-memory instruction reaches wb_* 2 edges after leaving EX; load/store adds N stall cycles for N cycles of dhit=0.
//
// - stall_cycles: +1 each edge where mem_stall=1 and state=RUN; saturates at all-ones.
//
// - Reset mid-access: the request drops immediately (async); no write-back occurs.
// TESTING
// 1. ALU op, memtoreg=0, wsel=5, aluout=32'h1234 -> 2 edges later wb_regwrite=1, wb_wsel=5, wb_wdat=32'h1234; mem_stall stays 0.
// 2. LW, aluout=32'h100, dhit low 3 cycles then high with dmemload=32'hCAFE ->
//    - dmemREN=1 and dmemaddr=32'h100 for 4 cycles; mem_stall=1 for 3 cycles.
//    - wb_wdat=32'hCAFE with wb_regwrite=1 exactly once.
//    - stall_cycles=3.
// 3. SW, storedata=32'hBEEF, dhit asserted first cycle -> dmemWEN=1 one cycle, dmemstore=32'hBEEF, mem_stall never asserted, wb_regwrite=0.
// 4. flush=1 with ex_regwrite=1 and ex_dmemWEN=1 -> no dmem request, no write-back; flush during mem_stall ignored.
// 5. wsel=0 with regwrite=1 -> wb_regwrite=0.
// 6. HALT after pending SW: SW completes first, then halt=1 and mem_stall=1 held.
//    - Later ex_* activity produces no requests or writes.
//    - nRST low clears halt and stall_cycles to 0.

Source files
------------

// File: rtl/ex_mem_wb_stage_if.sv
// Data-memory request/response bus between the EX/MEM/WB stage and the data cache.
interface ex_mem_wb_stage_if #(
   parameter int DATA_W = 32
);
   logic              dmemREN;
   logic              dmemWEN;
   logic [DATA_W-1:0] dmemaddr;
   logic [DATA_W-1:0] dmemstore;
   logic              dhit;
   logic [DATA_W-1:0] dmemload;

   modport master (
      output dmemREN, dmemWEN, dmemaddr, dmemstore,
      input  dhit, dmemload
   );

   modport slave (
      input  dmemREN, dmemWEN, dmemaddr, dmemstore,
      output dhit, dmemload
   );
endinterface

// File: rtl/ex_mem_wb_stage.sv
// EX/MEM and MEM/WB pipeline registers with the dmem request/dhit sequencer,
// write-back select, sticky halt and a saturating memory-stall counter.
module ex_mem_wb_stage #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic                CLK,
   input  logic                nRST,
   input  logic [DATA_W-1:0]   ex_aluout,
   input  logic [DATA_W-1:0]   ex_storedata,
   input  logic [DATA_W-1:0]   ex_npc,
   input  logic [DATA_W-1:0]   ex_upper,
   input  logic [4:0]          ex_wsel,
   input  logic                ex_regwrite,
   input  logic [1:0]          ex_memtoreg,
   input  logic                ex_dmemREN,
   input  logic                ex_dmemWEN,
   input  logic                ex_halt,
   input  logic                flush,
   ex_mem_wb_stage_if.master   dmem,
   output logic                mem_stall,
   output logic                wb_regwrite,
   output logic [4:0]          wb_wsel,
   output logic [DATA_W-1:0]   wb_wdat,
   output logic                halt,
   output logic [CNT_W-1:0]    stall_cycles
);

   typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

   typedef struct packed {
      logic [DATA_W-1:0] aluout;
      logic [DATA_W-1:0] storedata;
      logic [DATA_W-1:0] npc;
      logic [DATA_W-1:0] upper;
      logic [4:0]        wsel;
      logic              regwrite;
      logic [1:0]        memtoreg;
      logic              ren;
      logic              wen;
      logic              halt;
   } exmem_t;

   state_t            state_q, state_d;
   exmem_t            mem_q, mem_d;
   logic              wb_regwrite_q, wb_regwrite_d;
   logic [4:0]        wb_wsel_q, wb_wsel_d;
   logic [DATA_W-1:0] wb_wdat_q, wb_wdat_d;
   logic              halt_q, halt_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              run;
   logic              mem_req;
   logic              advance;
   logic [DATA_W-1:0] sel_wdat;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q       <= RUN;
         mem_q         <= '0;
         wb_regwrite_q <= 1'b0;
         wb_wsel_q     <= '0;
         wb_wdat_q     <= '0;
         halt_q        <= 1'b0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         mem_q         <= mem_d;
         wb_regwrite_q <= wb_regwrite_d;
         wb_wsel_q     <= wb_wsel_d;
         wb_wdat_q     <= wb_wdat_d;
         halt_q        <= halt_d;
         cnt_q         <= cnt_d;
      end
   end

   always_comb begin
      run     = (state_q == RUN);
      mem_req = mem_q.ren | mem_q.wen;

      // Request lines depend only on registered state, never on dhit.
      // A REN+WEN collision is issued as a store.
      dmem.dmemREN   = run & mem_q.ren & ~mem_q.wen;
      dmem.dmemWEN   = run & mem_q.wen;
      dmem.dmemaddr  = mem_q.aluout;
      dmem.dmemstore = mem_q.storedata;

      mem_stall = run ? (mem_req & ~dmem.dhit) : 1'b1;
      advance   = run & ~mem_stall;

      state_d = state_q;
      if (run && mem_q.halt && !mem_req) state_d = HALTED;

      // Stall wins over flush: the EX/MEM register simply holds.
      mem_d = mem_q;
      if (advance) begin
         mem_d.aluout    = ex_aluout;
         mem_d.storedata = ex_storedata;
         mem_d.npc       = ex_npc;
         mem_d.upper     = ex_upper;
         mem_d.wsel      = ex_wsel;
         mem_d.memtoreg  = ex_memtoreg;
         mem_d.regwrite  = ex_regwrite & ~flush;
         mem_d.ren       = ex_dmemREN  & ~flush;
         mem_d.wen       = ex_dmemWEN  & ~flush;
         mem_d.halt      = ex_halt     & ~flush;
      end

      case (mem_q.memtoreg)
         2'd0:    sel_wdat = mem_q.aluout;
         2'd1:    sel_wdat = dmem.dmemload;
         2'd2:    sel_wdat = mem_q.npc;
         default: sel_wdat = mem_q.upper;
      endcase

      // Any non-advancing edge inserts a write-back bubble so a write never repeats.
      wb_regwrite_d = 1'b0;
      wb_wsel_d     = wb_wsel_q;
      wb_wdat_d     = wb_wdat_q;
      if (advance) begin
         wb_regwrite_d = mem_q.regwrite & (mem_q.wsel != 5'd0);
         wb_wsel_d     = mem_q.wsel;
         wb_wdat_d     = sel_wdat;
      end

      halt_d = halt_q | (state_d == HALTED);

      cnt_d = cnt_q;
      if (run && mem_stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
   end

   assign wb_regwrite  = wb_regwrite_q;
   assign wb_wsel      = wb_wsel_q;
   assign wb_wdat      = wb_wdat_q;
   assign halt         = halt_q;
   assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_ex_mem_wb_stage.sv
// Scoreboard bench: dmem requests and write-backs are predicted at issue and
// matched as the stage produces them; a latency-programmable memory answers dhit.
module tb_ex_mem_wb_stage;
   localparam int DW = 32;
   localparam int CW = 16;

   typedef struct packed {
      logic [DW-1:0] aluout, storedata, npc, upper;
      logic [4:0]    wsel;
      logic          regwrite;
      logic [1:0]    memtoreg;
      logic          ren, wen, hlt;
   } ins_t;

   typedef struct { logic wen; logic [DW-1:0] addr; logic [DW-1:0] store; } req_t;
   typedef struct { logic [4:0] wsel; logic [DW-1:0] wdat; } wb_t;

   logic          CLK = 1'b0;
   logic          nRST = 1'b0;
   logic [DW-1:0] ex_aluout = '0, ex_storedata = '0, ex_npc = '0, ex_upper = '0;
   logic [4:0]    ex_wsel = '0;
   logic          ex_regwrite = 1'b0;
   logic [1:0]    ex_memtoreg = '0;
   logic          ex_dmemREN = 1'b0, ex_dmemWEN = 1'b0, ex_halt = 1'b0, flush = 1'b0;
   logic          mem_stall, wb_regwrite, halt;
   logic [4:0]    wb_wsel;
   logic [DW-1:0] wb_wdat;
   logic [CW-1:0] stall_cycles;

   logic [DW-1:0] load_val = '0;
   int            lat = 0;
   int            wcnt = 0;
   int            ren_cyc = 0, wen_cyc = 0;
   int            checks = 0, errors = 0;
   req_t          reqq[$];
   wb_t           wbq[$];

   ex_mem_wb_stage_if #(.DATA_W(DW)) dmem_bus ();

   ex_mem_wb_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
      .CLK(CLK), .nRST(nRST),
      .ex_aluout(ex_aluout), .ex_storedata(ex_storedata), .ex_npc(ex_npc), .ex_upper(ex_upper),
      .ex_wsel(ex_wsel), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
      .ex_dmemREN(ex_dmemREN), .ex_dmemWEN(ex_dmemWEN), .ex_halt(ex_halt), .flush(flush),
      .dmem(dmem_bus),
      .mem_stall(mem_stall), .wb_regwrite(wb_regwrite), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat),
      .halt(halt), .stall_cycles(stall_cycles)
   );

   always #5 CLK = ~CLK;

   assign dmem_bus.dmemload = load_val;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Memory model: answers dhit after `lat` cycles of a held request.
   initial dmem_bus.dhit = 1'b0;
   always @(negedge CLK) begin
      if (!nRST || !(dmem_bus.dmemREN || dmem_bus.dmemWEN)) begin
         dmem_bus.dhit = 1'b0;
         wcnt = 0;
      end else if (wcnt >= lat) begin
         dmem_bus.dhit = 1'b1;
         wcnt = 0;
      end else begin
         dmem_bus.dhit = 1'b0;
         wcnt++;
      end
   end

   always @(negedge CLK) begin
      #1;
      if (nRST) begin
         if (dmem_bus.dmemREN) ren_cyc++;
         if (dmem_bus.dmemWEN) wen_cyc++;
         if ((dmem_bus.dmemREN || dmem_bus.dmemWEN) && dmem_bus.dhit) begin
            if (reqq.size() == 0) chk("req_unexpected", 1, 0);
            else begin
               req_t r;
               r = reqq.pop_front();
               chk("req_wen", dmem_bus.dmemWEN, r.wen);
               chk("req_ren", dmem_bus.dmemREN, !r.wen);
               chk("req_addr", dmem_bus.dmemaddr, r.addr);
               if (r.wen) chk("req_store", dmem_bus.dmemstore, r.store);
            end
         end
         if (wb_regwrite) begin
            if (wbq.size() == 0) chk("wb_unexpected", 1, 0);
            else begin
               wb_t w;
               w = wbq.pop_front();
               chk("wb_wsel", wb_wsel, w.wsel);
               chk("wb_wdat", wb_wdat, w.wdat);
            end
         end
      end
   end

   function automatic ins_t alu(input logic [4:0] ws, input logic [1:0] m2r, input logic [DW-1:0] v);
      ins_t i;
      i = '0;
      i.wsel = ws; i.regwrite = 1'b1; i.memtoreg = m2r;
      i.aluout = v; i.npc = v ^ 32'h0000_0F00; i.upper = {v[15:0], 16'h0};
      return i;
   endfunction

   task automatic drive(input ins_t i);
      ex_aluout = i.aluout; ex_storedata = i.storedata; ex_npc = i.npc; ex_upper = i.upper;
      ex_wsel = i.wsel; ex_regwrite = i.regwrite; ex_memtoreg = i.memtoreg;
      ex_dmemREN = i.ren; ex_dmemWEN = i.wen; ex_halt = i.hlt;
   endtask

   // Hold an instruction in EX until an edge consumes it; push its predicted effects.
   task automatic issue(input ins_t i, input logic fl);
      logic st;
      int   n;
      logic [DW-1:0] wd;
      drive(i);
      flush = fl;
      n = 0;
      do begin
         @(negedge CLK); #1;
         st = mem_stall;
         @(posedge CLK); #1;
         n++;
      end while (st && n < 50);
      if (st) chk("issue_timeout", 1, 0);
      else if (!fl) begin
         if (i.ren || i.wen) reqq.push_back('{i.wen, i.aluout, i.storedata});
         if (i.regwrite && i.wsel != 0) begin
            case (i.memtoreg)
               2'd0: wd = i.aluout;
               2'd1: wd = load_val;
               2'd2: wd = i.npc;
               default: wd = i.upper;
            endcase
            wbq.push_back('{i.wsel, wd});
         end
      end
      flush = 1'b0;
      drive('0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   initial begin
      ins_t i;
      int   base, wbase;
      logic st;

      // Reset state
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_ren", dmem_bus.dmemREN, 0);
      chk("rst_wen", dmem_bus.dmemWEN, 0);
      chk("rst_addr", dmem_bus.dmemaddr, 0);
      chk("rst_stall", mem_stall, 0);
      chk("rst_wbwe", wb_regwrite, 0);
      chk("rst_wdat", wb_wdat, 0);
      chk("rst_halt", halt, 0);
      chk("rst_cnt", stall_cycles, 0);
      nRST = 1'b1;
      idle(1);

      // 1: ALU op, two-edge latency
      issue(alu(5'd5, 2'd0, 32'h1234), 1'b0);
      chk("t1_wb_early", wb_regwrite, 0);
      idle(1);
      chk("t1_wbwe", wb_regwrite, 1);
      chk("t1_wsel", wb_wsel, 5);
      chk("t1_wdat", wb_wdat, 32'h1234);
      chk("t1_stall", mem_stall, 0);
      issue(alu(5'd6, 2'd2, 32'h4000), 1'b0);
      issue(alu(5'd7, 2'd3, 32'h0000ABCD), 1'b0);
      idle(3);

      // 2: LW with three dhit-low cycles
      lat = 3; load_val = 32'hCAFE; ren_cyc = 0;
      i = alu(5'd8, 2'd1, 32'h100); i.ren = 1'b1;
      issue(i, 1'b0);
      idle(8);
      chk("t2_ren_cycles", ren_cyc, 4);
      chk("t2_stall_cnt", stall_cycles, 3);

      // 3: SW hit first cycle, then a REN+WEN collision treated as store
      lat = 0; wen_cyc = 0; base = int'(stall_cycles);
      i = '0; i.wen = 1'b1; i.aluout = 32'h200; i.storedata = 32'hBEEF;
      issue(i, 1'b0);
      idle(4);
      chk("t3_wen_cycles", wen_cyc, 1);
      chk("t3_stall_cnt", stall_cycles, base);
      i.ren = 1'b1; i.aluout = 32'h204; i.storedata = 32'h5A5A;
      issue(i, 1'b0);
      idle(4);
      chk("t3_collide_ren", ren_cyc, 4);

      // 4: flush squashes a store+write; flush during a stall is ignored
      wen_cyc = 0;
      i = alu(5'd9, 2'd0, 32'h300); i.wen = 1'b1;
      issue(i, 1'b1);
      idle(4);
      chk("t4_flush_wen", wen_cyc, 0);
      lat = 2; load_val = 32'h7777; base = int'(stall_cycles);
      i = alu(5'd10, 2'd1, 32'h400); i.ren = 1'b1;
      issue(i, 1'b0);
      drive(alu(5'd11, 2'd0, 32'h1111));
      flush = 1'b1;
      wbase = 0;
      do begin
         @(negedge CLK); #1;
         st = mem_stall;
         if (!st) flush = 1'b0;
         @(posedge CLK); #1;
         wbase++;
      end while (st && wbase < 50);
      chk("t4_stall_len", wbase, 3);
      wbq.push_back('{5'd11, 32'h1111});
      drive('0);
      idle(4);
      chk("t4_stall_cnt", stall_cycles, base + 2);

      // 5: write to r0 suppressed
      lat = 0;
      issue(alu(5'd0, 2'd0, 32'hDEAD), 1'b0);
      idle(3);

      // 6: HALT behind a pending SW
      lat = 2; wen_cyc = 0;
      i = '0; i.wen = 1'b1; i.aluout = 32'h500; i.storedata = 32'h600D;
      issue(i, 1'b0);
      chk("t6_halt_early", halt, 0);
      i = '0; i.hlt = 1'b1;
      issue(i, 1'b0);
      chk("t6_sw_done", wen_cyc, 3);
      idle(2);
      chk("t6_halt", halt, 1);
      chk("t6_stall", mem_stall, 1);
      wen_cyc = 0; ren_cyc = 0; base = int'(stall_cycles);
      i = alu(5'd12, 2'd0, 32'h900); i.wen = 1'b1;
      drive(i);
      idle(5);
      drive('0);
      chk("t6_no_req", wen_cyc + ren_cyc, 0);
      chk("t6_cnt_frozen", stall_cycles, base);
      chk("t6_halt_held", halt, 1);
      #2 nRST = 1'b0;
      #1;
      chk("t6_rst_halt", halt, 0);
      chk("t6_rst_cnt", stall_cycles, 0);
      chk("t6_rst_stall", mem_stall, 0);

      chk("req_queue_empty", reqq.size(), 0);
      chk("wb_queue_empty", wbq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
